// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the fetch front-end and its consumers.
// fetch_entry_t is the {pc, instr} pair handed to decode.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'h0000_0001;
  localparam int          FETCH_DEPTH      = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch bus: instruction-memory read port, decode handshake and redirect.
// master = fetch unit, slave = the memory/decode/branch side.
interface instruction_fetch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] instructionIn;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] pc_out;
  logic             instr_valid;
  logic             instr_ready;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;

  modport master (
    output address, instr_out, pc_out, instr_valid,
    input  instructionIn, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  address, instr_out, pc_out, instr_valid,
    output instructionIn, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// Two-entry {pc, instr} FIFO between the memory read port and decode.
// Flush wins over push and pop; entries reset to {0, NOP} so head outputs are defined.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_instr,
  input  logic             pop,
  input  logic             flush,
  output logic [1:0]       count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_pc,
  output logic [WIDTH-1:0] head_instr
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push;
  logic       do_pop;

  logic [WIDTH-1:0] entry_pc    [FETCH_DEPTH];
  logic [WIDTH-1:0] entry_instr [FETCH_DEPTH];

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && (count_q != 2'd0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_DEPTH; gi++) begin : g_entry
      logic             wr_en;
      logic [WIDTH-1:0] pc_q, pc_d;
      logic [WIDTH-1:0] instr_q, instr_d;

      assign wr_en = do_push && (wr_ptr_q == 1'(gi));

      always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (wr_en) begin
          pc_d    = push_pc;
          instr_d = push_instr;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pc_q    <= '0;
          instr_q <= WIDTH'(NOP_INSTR);
        end else begin
          pc_q    <= pc_d;
          instr_q <= instr_d;
        end
      end

      assign entry_pc[gi]    = pc_q;
      assign entry_instr[gi] = instr_q;
    end
  endgenerate

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_pc    = entry_pc[rd_ptr_q];
  assign head_instr = entry_instr[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front-end: owns the fetch PC, tracks the one in-flight memory read and
// only issues when the buffer is guaranteed room for the returning word.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(DEFAULT_PC_STEP)
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] pending_pc_q, pending_pc_d;

  logic [1:0]       buf_count;
  logic             head_valid;
  logic [WIDTH-1:0] head_pc;
  logic [WIDTH-1:0] head_instr;
  logic             pop;
  logic             issue;
  logic [2:0]       occupancy;

  // Credit check: entries held plus the word in flight, minus what leaves this edge.
  always_comb begin
    pop          = head_valid && bus.instr_ready;
    occupancy    = {1'b0, buf_count} + {2'b00, pending_q} - {2'b00, pop};
    issue        = !bus.redirect && (occupancy < 3'd2);
    fetch_pc_d   = fetch_pc_q;
    pending_d    = issue;
    pending_pc_d = pending_pc_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue) begin
      fetch_pc_d   = fetch_pc_q + PC_STEP;
      pending_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  fetch_buffer #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (pending_q),
    .push_pc    (pending_pc_q),
    .push_instr (bus.instructionIn),
    .pop        (pop),
    .flush      (bus.redirect),
    .count      (buf_count),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  assign bus.address     = fetch_pc_q;
  assign bus.instr_valid = head_valid;
  assign bus.pc_out      = head_pc;
  assign bus.instr_out   = head_instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: directed phases push expected
// {pc, instr} pairs, per-DUT monitors pop and compare on every accepted beat.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk;
  logic rst1_n;
  logic rst2_n;
  int   total;
  int   bad;

  fetch_entry_t exp1_q[$];
  fetch_entry_t exp2_q[$];

  instruction_fetch_if #(.WIDTH(32)) bus1 ();
  instruction_fetch_if #(.WIDTH(32)) bus2 ();

  instruction_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000), .PC_STEP(32'h1)) dut (
    .clk   (clk),
    .reset (rst1_n),
    .bus   (bus1.master)
  );

  instruction_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFE), .PC_STEP(32'h1)) dut_wrap (
    .clk   (clk),
    .reset (rst2_n),
    .bus   (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory model: mem[i] = A000_0000 + i.
  always @(posedge clk) begin
    bus1.instructionIn <= 32'hA000_0000 + bus1.address;
    bus2.instructionIn <= 32'hA000_0000 + bus2.address;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic exp1(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = 32'hA000_0000 + pc;
    exp1_q.push_back(e);
  endtask

  task automatic exp2(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = 32'hA000_0000 + pc;
    exp2_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: a beat is accepted when valid && ready and no redirect voids it.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst1_n && bus1.instr_valid && bus1.instr_ready && !bus1.redirect) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut_unexpected_beat actual_pc=%h required=none", bus1.pc_out);
      end else begin
        e = exp1_q.pop_front();
        check("dut_beat_pc", bus1.pc_out, e.pc);
        check("dut_beat_instr", bus1.instr_out, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst2_n && bus2.instr_valid && bus2.instr_ready && !bus2.redirect) begin
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wrap_unexpected_beat actual_pc=%h required=none", bus2.pc_out);
      end else begin
        e = exp2_q.pop_front();
        check("wrap_beat_pc", bus2.pc_out, e.pc);
        check("wrap_beat_instr", bus2.instr_out, e.instr);
      end
    end
  end

  // A returning word must always find room in the buffer.
  always @(negedge clk) begin
    if (rst1_n && dut.pending_q && !bus1.redirect) begin
      total++;
      if (dut.buf_count == 2'd2 && !(bus1.instr_valid && bus1.instr_ready)) begin
        bad++;
        $display("FAIL no_overflow actual_count=%0d required=below_2_or_pop", dut.buf_count);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    bus1.instr_ready = 1'b1;
    bus1.redirect    = 1'b0;
    bus1.redirect_pc = 32'h0;
    bus2.instr_ready = 1'b1;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'h0;

    // Reset values.
    tick(1);
    check("rst_address", bus1.address, 32'h0);
    check("rst_valid", {31'b0, bus1.instr_valid}, 32'h0);
    check("rst_pc_out", bus1.pc_out, 32'h0);
    check("rst_instr_out", bus1.instr_out, 32'h0000_0013);
    check("rst_wrap_address", bus2.address, 32'hFFFF_FFFE);

    // Release; stream with ready held high.
    @(posedge clk);
    #3;
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    for (int i = 0; i < 8; i++) exp1(32'(i));
    exp2(32'hFFFF_FFFE);
    exp2(32'hFFFF_FFFF);
    exp2(32'h0);
    exp2(32'h1);
    exp2(32'h2);
    tick(1);
    check("first_edge_valid", {31'b0, bus1.instr_valid}, 32'h0);
    tick(1);
    check("second_edge_valid", {31'b0, bus1.instr_valid}, 32'h1);
    check("second_edge_pc", bus1.pc_out, 32'h0);
    tick(5);
    bus2.instr_ready = 1'b0;
    check("wrap_all_delivered", exp2_q.size(), 32'h0);
    tick(3);
    bus1.instr_ready = 1'b0;
    check("stream_no_gap", exp1_q.size(), 32'h0);

    // Backpressure for 5 cycles.
    tick(2);
    check("bp_address_early", bus1.address, 32'd10);
    check("bp_count_early", {30'b0, dut.buf_count}, 32'd2);
    tick(3);
    check("bp_address_late", bus1.address, 32'd10);
    check("bp_count_late", {30'b0, dut.buf_count}, 32'd2);
    check("bp_head_pc", bus1.pc_out, 32'd8);
    for (int i = 8; i < 12; i++) exp1(32'(i));
    bus1.instr_ready = 1'b1;
    tick(4);
    bus1.instr_ready = 1'b0;
    check("bp_resume_in_order", exp1_q.size(), 32'h0);
    tick(2);
    check("full_before_reset", {30'b0, dut.buf_count}, 32'd2);
    check("full_address", bus1.address, 32'd14);

    // Reset mid-stream between edges with the buffer full.
    #2;
    rst1_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, bus1.instr_valid}, 32'h0);
    check("mid_rst_pc_out", bus1.pc_out, 32'h0);
    check("mid_rst_instr_out", bus1.instr_out, 32'h0000_0013);
    check("mid_rst_address", bus1.address, 32'h0);
    @(posedge clk);
    #3;
    rst1_n = 1'b1;
    bus1.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp1(32'(i));

    // Redirect right after PC 4 is consumed; PCs 5 and 6 must vanish.
    tick(7);
    check("restart_in_order", exp1_q.size(), 32'h0);
    bus1.redirect    = 1'b1;
    bus1.redirect_pc = 32'h40;
    for (int i = 'h40; i < 'h44; i++) exp1(32'(i));
    tick(1);
    bus1.redirect = 1'b0;
    check("redir_e0_valid", {31'b0, bus1.instr_valid}, 32'h0);
    check("redir_e0_address", bus1.address, 32'h40);
    tick(1);
    check("redir_e1_valid", {31'b0, bus1.instr_valid}, 32'h0);
    tick(1);
    check("redir_e2_valid", {31'b0, bus1.instr_valid}, 32'h1);
    check("redir_e2_pc", bus1.pc_out, 32'h40);
    tick(4);
    bus1.instr_ready = 1'b0;
    check("redir_stream_done", exp1_q.size(), 32'h0);

    // Redirect coinciding with a pop while full.
    tick(2);
    check("full_before_redir", {30'b0, dut.buf_count}, 32'd2);
    bus1.instr_ready = 1'b1;
    bus1.redirect    = 1'b1;
    bus1.redirect_pc = 32'h80;
    exp1(32'h80);
    exp1(32'h81);
    tick(1);
    bus1.redirect = 1'b0;
    check("redir_pop_valid", {31'b0, bus1.instr_valid}, 32'h0);
    tick(2);
    check("redir_pop_head", bus1.pc_out, 32'h80);
    tick(2);
    bus1.instr_ready = 1'b0;
    check("redir_pop_done", exp1_q.size(), 32'h0);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
